fv_req_xbar: RTL and testbench
==============================

Name: fv_req_xbar

Overview:
- Request crossbar directly upstream of the Big FV bank controllers.
- Accepts one feature-vector request per cycle from each Edge PE and routes it to bank (Node_id mod NUM_BANKS).
- Arbitrates round-robin per bank and keeps a bank locked to one PE for a whole write stream (wr_sos..wr_eos).
- Drives the per-bank req_pkt fields (valid, PE_tag, rd_wr, Node_id, data, wr_sos, wr_eos) from registers.

Parameters:
- NUM_PE, 4, number of Edge PEs (`Num_Edge_PE)
- NUM_BANKS, 4, number of FV banks (`Num_Banks_all_FV); power of two
- NODE_ID_W, 8, $clog2(`Max_Node_id)
- FV_BW, 16, `FV_bandwidth
- TAG_W, 2, $clog2(NUM_PE)

Ports:
- clk  in  1  clock; all logic rising-edge
- reset  in  1  synchronous, active-high reset
- available  in  1  AND of all bank-controller available flags; 0 blocks every grant
- pe_req_valid  in  NUM_PE  per-PE request valid
- pe_req_rd_wr  in  NUM_PE  1 = write, 0 = read
- pe_req_node_id  in  NUM_PE*NODE_ID_W  packed per PE; PE p in slice p
- pe_req_data  in  NUM_PE*FV_BW  write data
- pe_req_wr_sos  in  NUM_PE  write-stream start
- pe_req_wr_eos  in  NUM_PE  write-stream end
- pe_req_ready  out  NUM_PE  combinational grant; transfer = valid & ready
- bank_req_valid  out  NUM_BANKS  registered
- bank_req_PE_tag  out  NUM_BANKS*TAG_W  index of source PE
- bank_req_rd_wr  out  NUM_BANKS  forwarded
- bank_req_node_id  out  NUM_BANKS*NODE_ID_W  full Node_id, forwarded unmodified
- bank_req_data  out  NUM_BANKS*FV_BW  forwarded
- bank_req_wr_sos  out  NUM_BANKS  forwarded
- bank_req_wr_eos  out  NUM_BANKS  forwarded

Behaviour:
- Bank select: b = node_id[$clog2(NUM_BANKS)-1:0]. Each PE targets exactly one bank per cycle, so at most one grant per PE.
- Per-bank candidates are the PEs with valid=1 and matching b.
- No grants anywhere while available=0; pe_req_ready = 0 for all PEs.
- Unlocked bank grants the first candidate at or after rr_ptr[b], scanning upward with wrap at NUM_PE-1 to 0. On a grant, rr_ptr[b] becomes winner+1 mod NUM_PE.
- Locked bank considers only lock_owner[b]; other candidates stall with ready=0. rr_ptr[b] is held while locked.
- Lock set: granted pkt with rd_wr=1, wr_sos=1, wr_eos=0 sets lock[b]=1 and lock_owner[b]=winner.
- Lock clear: granted pkt from lock_owner with rd_wr=1 and wr_eos=1. A pkt with sos=eos=1 never locks.
- Read packets never set or clear a lock; sos/eos bits are forwarded as-is.
- Output: on a grant to bank b, all bank_req_* fields of b register the winner's fields next edge, with PE_tag = winner and valid=1. Latency is 1 cycle from handshake to bank_req_valid.
- With no grant, bank_req_valid[b] = 0 next cycle and the other bank fields hold their previous values.
- Banks arbitrate independently, so up to min(NUM_PE, NUM_BANKS) grants per cycle.
- available falling mid-stream: grants stop and lock and owner are retained.
- Reset, including mid-stream: all outputs 0, rr_ptr = 0, lock = 0, owner = 0. The interrupted stream is dropped with no recovery.
- pe_req_ready may depend on pe_req_valid, but valid must not depend on ready.

Decomposition:
- Shared package, alongside the existing Req2Output_SRAM_Bank struct:
  - PE-side request struct (valid, rd_wr, Node_id, data, wr_sos, wr_eos).
  - bank_sel() function.
  - Width constants TAG_W and NODE_ID_W.
- Sub-module fv_rr_arbiter: NUM_PE-wide rotating-priority arbiter with inputs req, ptr, hold_mask and a one-hot grant output. Instantiate once per bank.

Test Plan:
- Reset, then PE0 read node 0x05, available=1 -> ready[0]=1 that cycle; next cycle bank_req_valid = 4'b0010, PE_tag[1] = 0, node_id[1] = 0x05.
- PEs 0–3 read nodes 0x04/0x08/0x0C/0x10 (all bank 0), held valid -> grants PE0, 1, 2, 3 on consecutive cycles; bank-0 valid high 4 cycles; PE_tag sequence 0,1,2,3.
- PE2 write stream of 3 pkts to node 0x01 (sos, mid, eos) while PE0 and PE3 request bank 1 -> PE2 owns bank 1 for 3 consecutive grants; PE3 is granted on the cycle after PE2's eos handshake, then PE0.
- PEs 0–3 target banks 0, 1, 2, 3 simultaneously -> all four ready=1 in one cycle; next cycle bank_req_valid = 4'b1111 with PE_tag[b] = b.
- available=0 for 2 cycles with PE1 valid -> ready[1]=0 and bank_req_valid=0; granted the cycle available returns to 1.
- Reset asserted after PE1 wr_sos to bank 3 -> after reset, PE0 is granted bank 3 immediately (lock cleared, rr_ptr = 0).

Source files
------------

// File: rtl/fv_req_xbar_pkg.sv
// ============================================================================
// Module      : fv_req_xbar_pkg
// Description : Shared types, widths and the bank-select helper for the
//               feature-vector request crossbar and the Big FV banks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fv_req_xbar_pkg;

  // Default crossbar geometry; the top-level parameters take these as defaults
  localparam int NUM_PE_DFLT    = 4;
  localparam int NUM_BANKS_DFLT = 4;
  localparam int FV_BW_DFLT     = 16;

  // Field widths shared with the bank controllers
  localparam int NODE_ID_W = 8;
  localparam int TAG_W     = $clog2(NUM_PE_DFLT);

  // Request as presented by one Edge PE
  typedef struct packed {
    logic                  valid;
    logic                  rd_wr;
    logic [NODE_ID_W-1:0]  node_id;
    logic [FV_BW_DFLT-1:0] data;
    logic                  wr_sos;
    logic                  wr_eos;
  } pe_req_t;

  // Request as delivered to one SRAM bank controller
  typedef struct packed {
    logic                  valid;
    logic [TAG_W-1:0]      PE_tag;
    logic                  rd_wr;
    logic [NODE_ID_W-1:0]  Node_id;
    logic [FV_BW_DFLT-1:0] data;
    logic                  wr_sos;
    logic                  wr_eos;
  } Req2Output_SRAM_Bank;

  // Bank index is the low bits of the node id; num_banks is a power of two
  function automatic int unsigned bank_sel(input logic [31:0] node_id,
                                           input int unsigned num_banks);
    return node_id & (num_banks - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fv_rr_arbiter.sv
// ============================================================================
// Module      : fv_rr_arbiter
// Description : N-wide rotating-priority arbiter. The first request at or
//               above ptr_i (wrapping) that survives hold_mask_i is granted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fv_rr_arbiter
  import fv_req_xbar_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic [N-1:0]     hold_mask_i,
  output logic [N-1:0]     grant_o
);

  logic [N-1:0]   masked_w;
  logic [PTR_W:0] sum_w;
  logic [PTR_W-1:0] idx_w;
  logic           found_w;

  assign masked_w = req_i & hold_mask_i;

  // Scan upward from the pointer, wrapping at N-1, and grant the first hit
  always_comb begin
    grant_o = '0;
    found_w = 1'b0;
    sum_w   = '0;
    idx_w   = '0;
    for (int i = 0; i < N; i++) begin
      sum_w = {1'b0, ptr_i} + (PTR_W+1)'(i);
      if (sum_w >= (PTR_W+1)'(N)) begin
        sum_w = sum_w - (PTR_W+1)'(N);
      end
      idx_w = sum_w[PTR_W-1:0];
      if (!found_w && masked_w[idx_w]) begin
        grant_o[idx_w] = 1'b1;
        found_w        = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fv_req_xbar.sv
// ============================================================================
// Module      : fv_req_xbar
// Description : Edge-PE to Big-FV-bank request crossbar. Per-bank round-robin
//               arbitration with write-stream locking and registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fv_req_xbar #(
  parameter int NUM_PE    = fv_req_xbar_pkg::NUM_PE_DFLT,
  parameter int NUM_BANKS = fv_req_xbar_pkg::NUM_BANKS_DFLT,
  parameter int NODE_ID_W = fv_req_xbar_pkg::NODE_ID_W,
  parameter int FV_BW     = fv_req_xbar_pkg::FV_BW_DFLT,
  parameter int TAG_W     = $clog2(NUM_PE)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           available,
  input  logic [NUM_PE-1:0]              pe_req_valid,
  input  logic [NUM_PE-1:0]              pe_req_rd_wr,
  input  logic [NUM_PE*NODE_ID_W-1:0]    pe_req_node_id,
  input  logic [NUM_PE*FV_BW-1:0]        pe_req_data,
  input  logic [NUM_PE-1:0]              pe_req_wr_sos,
  input  logic [NUM_PE-1:0]              pe_req_wr_eos,
  output logic [NUM_PE-1:0]              pe_req_ready,
  output logic [NUM_BANKS-1:0]           bank_req_valid,
  output logic [NUM_BANKS*TAG_W-1:0]     bank_req_PE_tag,
  output logic [NUM_BANKS-1:0]           bank_req_rd_wr,
  output logic [NUM_BANKS*NODE_ID_W-1:0] bank_req_node_id,
  output logic [NUM_BANKS*FV_BW-1:0]     bank_req_data,
  output logic [NUM_BANKS-1:0]           bank_req_wr_sos,
  output logic [NUM_BANKS-1:0]           bank_req_wr_eos
);

  import fv_req_xbar_pkg::*;

  logic [NUM_PE-1:0] grant_w [NUM_BANKS];

  // A PE targets one bank per cycle, so its ready is the OR of all bank grants
  always_comb begin
    pe_req_ready = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      pe_req_ready = pe_req_ready | grant_w[b];
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [NUM_PE-1:0]    cand_w;
    logic [NUM_PE-1:0]    mask_w;
    logic                 any_w;
    logic [TAG_W-1:0]     win_w;
    logic                 win_rd_wr_w;
    logic                 win_sos_w;
    logic                 win_eos_w;
    logic [NODE_ID_W-1:0] win_node_w;
    logic [FV_BW-1:0]     win_data_w;

    logic                 valid_q;
    logic [TAG_W-1:0]     tag_q;
    logic                 rd_wr_q;
    logic [NODE_ID_W-1:0] node_q;
    logic [FV_BW-1:0]     data_q;
    logic                 sos_q;
    logic                 eos_q;
    logic [TAG_W-1:0]     ptr_q;
    logic                 lock_q;
    logic [TAG_W-1:0]     owner_q;

    // Candidates: valid PEs whose node id maps here; nothing while unavailable
    always_comb begin
      cand_w = '0;
      for (int p = 0; p < NUM_PE; p++) begin
        cand_w[p] = available && pe_req_valid[p] &&
                    (bank_sel(32'(pe_req_node_id[p*NODE_ID_W +: NODE_ID_W]),
                              NUM_BANKS) == b);
      end
    end

    // While a write stream holds the bank only its owner may be granted
    assign mask_w = lock_q ? ({{(NUM_PE-1){1'b0}}, 1'b1} << owner_q) : '1;

    fv_rr_arbiter #(
      .N     (NUM_PE),
      .PTR_W (TAG_W)
    ) u_arb (
      .req_i       (cand_w),
      .ptr_i       (ptr_q),
      .hold_mask_i (mask_w),
      .grant_o     (grant_w[b])
    );

    // Encode the one-hot grant and select the winner's request fields
    always_comb begin
      any_w       = |grant_w[b];
      win_w       = '0;
      win_rd_wr_w = 1'b0;
      win_sos_w   = 1'b0;
      win_eos_w   = 1'b0;
      win_node_w  = '0;
      win_data_w  = '0;
      for (int p = 0; p < NUM_PE; p++) begin
        if (grant_w[b][p]) begin
          win_w       = TAG_W'(p);
          win_rd_wr_w = pe_req_rd_wr[p];
          win_sos_w   = pe_req_wr_sos[p];
          win_eos_w   = pe_req_wr_eos[p];
          win_node_w  = pe_req_node_id[p*NODE_ID_W +: NODE_ID_W];
          win_data_w  = pe_req_data[p*FV_BW +: FV_BW];
        end
      end
    end

    // Register the granted packet, advance the pointer and track stream locks
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
        tag_q   <= '0;
        rd_wr_q <= 1'b0;
        node_q  <= '0;
        data_q  <= '0;
        sos_q   <= 1'b0;
        eos_q   <= 1'b0;
        ptr_q   <= '0;
        lock_q  <= 1'b0;
        owner_q <= '0;
      end else begin
        valid_q <= any_w;
        if (any_w) begin
          tag_q   <= win_w;
          rd_wr_q <= win_rd_wr_w;
          node_q  <= win_node_w;
          data_q  <= win_data_w;
          sos_q   <= win_sos_w;
          eos_q   <= win_eos_w;
          if (!lock_q) begin
            ptr_q <= (win_w == TAG_W'(NUM_PE-1)) ? '0 : win_w + TAG_W'(1);
            // A single-packet write (sos and eos together) never locks
            if (win_rd_wr_w && win_sos_w && !win_eos_w) begin
              lock_q  <= 1'b1;
              owner_q <= win_w;
            end
          end else if (win_rd_wr_w && win_eos_w) begin
            lock_q <= 1'b0;
          end
        end
      end
    end

    assign bank_req_valid[b]                         = valid_q;
    assign bank_req_PE_tag[b*TAG_W +: TAG_W]         = tag_q;
    assign bank_req_rd_wr[b]                         = rd_wr_q;
    assign bank_req_node_id[b*NODE_ID_W +: NODE_ID_W] = node_q;
    assign bank_req_data[b*FV_BW +: FV_BW]           = data_q;
    assign bank_req_wr_sos[b]                        = sos_q;
    assign bank_req_wr_eos[b]                        = eos_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_fv_req_xbar.sv
// ============================================================================
// Module      : tb_fv_req_xbar
// Description : Table-driven self-checking bench for fv_req_xbar with an
//               expected-output queue for the registered bank side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fv_req_xbar;

  logic        clk = 1'b0;
  logic        reset;
  logic        available;
  logic [3:0]  pe_req_valid;
  logic [3:0]  pe_req_rd_wr;
  logic [31:0] pe_req_node_id;
  logic [63:0] pe_req_data;
  logic [3:0]  pe_req_wr_sos;
  logic [3:0]  pe_req_wr_eos;
  logic [3:0]  pe_req_ready;
  logic [3:0]  bank_req_valid;
  logic [7:0]  bank_req_PE_tag;
  logic [3:0]  bank_req_rd_wr;
  logic [31:0] bank_req_node_id;
  logic [63:0] bank_req_data;
  logic [3:0]  bank_req_wr_sos;
  logic [3:0]  bank_req_wr_eos;

  fv_req_xbar dut (
    .clk              (clk),
    .reset            (reset),
    .available        (available),
    .pe_req_valid     (pe_req_valid),
    .pe_req_rd_wr     (pe_req_rd_wr),
    .pe_req_node_id   (pe_req_node_id),
    .pe_req_data      (pe_req_data),
    .pe_req_wr_sos    (pe_req_wr_sos),
    .pe_req_wr_eos    (pe_req_wr_eos),
    .pe_req_ready     (pe_req_ready),
    .bank_req_valid   (bank_req_valid),
    .bank_req_PE_tag  (bank_req_PE_tag),
    .bank_req_rd_wr   (bank_req_rd_wr),
    .bank_req_node_id (bank_req_node_id),
    .bank_req_data    (bank_req_data),
    .bank_req_wr_sos  (bank_req_wr_sos),
    .bank_req_wr_eos  (bank_req_wr_eos)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus plus what the DUT must do with it
  typedef struct packed {
    logic        rst_before;
    logic        avail;
    logic [3:0]  v;
    logic [3:0]  rw;
    logic [3:0]  sos;
    logic [3:0]  eos;
    logic [31:0] nodes;    // {n3, n2, n1, n0}
    logic [3:0]  exp_rdy;
    logic [3:0]  exp_bv;
    logic [7:0]  exp_tag;  // winner PE per bank, bank b at [2b+:2]
  } vec_t;

  // Full expected bank-side state one cycle after a vector
  typedef struct packed {
    logic [3:0]  bv;
    logic [7:0]  tag;
    logic [3:0]  rw;
    logic [31:0] node;
    logic [63:0] data;
    logic [3:0]  sos;
    logic [3:0]  eos;
  } exp_t;

  localparam int NV = 17;
  vec_t  vecs [NV];
  exp_t  sb_q [$];
  exp_t  shadow;
  int    n_vec = 0;
  int    n_chk = 0;
  int    n_err = 0;

  function automatic logic [15:0] data_for(input int p, input logic [7:0] node, input int idx);
    return {4'(idx), 4'(p), node};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    available      = 1'b1;
    pe_req_valid   = '0;
    pe_req_rd_wr   = '0;
    pe_req_node_id = '0;
    pe_req_data    = '0;
    pe_req_wr_sos  = '0;
    pe_req_wr_eos  = '0;
  endtask

  task automatic compare_bank(input string tag, input exp_t e);
    chk({tag, " bank_valid"}, 64'(bank_req_valid),   64'(e.bv));
    chk({tag, " PE_tag"},     64'(bank_req_PE_tag),  64'(e.tag));
    chk({tag, " rd_wr"},      64'(bank_req_rd_wr),   64'(e.rw));
    chk({tag, " node_id"},    64'(bank_req_node_id), 64'(e.node));
    chk({tag, " data"},       bank_req_data,         e.data);
    chk({tag, " wr_sos"},     64'(bank_req_wr_sos),  64'(e.sos));
    chk({tag, " wr_eos"},     64'(bank_req_wr_eos),  64'(e.eos));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    shadow = '0;
    compare_bank("reset", shadow);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic apply(input int i);
    vec_t  t;
    exp_t  e;
    int    w;
    t = vecs[i];
    @(negedge clk);
    available      = t.avail;
    pe_req_valid   = t.v;
    pe_req_rd_wr   = t.rw;
    pe_req_wr_sos  = t.sos;
    pe_req_wr_eos  = t.eos;
    pe_req_node_id = t.nodes;
    for (int p = 0; p < 4; p++) begin
      pe_req_data[16*p +: 16] = data_for(p, t.nodes[8*p +: 8], i);
    end
    n_vec++;
    #1;
    chk($sformatf("v%0d ready", i), 64'(pe_req_ready), 64'(t.exp_rdy));
    // Granted banks take the winner's fields; others hold their last value
    e    = shadow;
    e.bv = t.exp_bv;
    for (int b = 0; b < 4; b++) begin
      if (t.exp_bv[b]) begin
        w                = int'(t.exp_tag[2*b +: 2]);
        e.tag[2*b +: 2]  = t.exp_tag[2*b +: 2];
        e.node[8*b +: 8] = t.nodes[8*w +: 8];
        e.data[16*b +: 16] = data_for(w, t.nodes[8*w +: 8], i);
        e.rw[b]  = t.rw[w];
        e.sos[b] = t.sos[w];
        e.eos[b] = t.eos[w];
      end
    end
    shadow = e;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL v%0d scoreboard: got empty queue expected one entry", i);
    end else begin
      compare_bank($sformatf("v%0d", i), sb_q.pop_front());
    end
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    shadow = '0;

    //          rst   av    v        rw       sos      eos      {n3,n2,n1,n0}              rdy      bv       tag
    // single read to bank 1
    vecs[0]  = '{1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, {8'h00,8'h00,8'h00,8'h05}, 4'b0001, 4'b0010, 8'h00};
    // four reads to bank 0, each PE drops valid once granted
    vecs[1]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, {8'h10,8'h0C,8'h08,8'h04}, 4'b0001, 4'b0001, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 4'b1110, 4'b0000, 4'b0000, 4'b0000, {8'h10,8'h0C,8'h08,8'h04}, 4'b0010, 4'b0001, 8'h01};
    vecs[3]  = '{1'b0, 1'b1, 4'b1100, 4'b0000, 4'b0000, 4'b0000, {8'h10,8'h0C,8'h08,8'h04}, 4'b0100, 4'b0001, 8'h02};
    vecs[4]  = '{1'b0, 1'b1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, {8'h10,8'h0C,8'h08,8'h04}, 4'b1000, 4'b0001, 8'h03};
    // PE2 write stream locks bank 1 while PE0 and PE3 wait
    vecs[5]  = '{1'b1, 1'b1, 4'b0100, 4'b0100, 4'b0100, 4'b0000, {8'h00,8'h01,8'h00,8'h00}, 4'b0100, 4'b0010, 8'h08};
    vecs[6]  = '{1'b0, 1'b1, 4'b1101, 4'b0100, 4'b0000, 4'b0000, {8'h09,8'h01,8'h00,8'h05}, 4'b0100, 4'b0010, 8'h08};
    vecs[7]  = '{1'b0, 1'b1, 4'b1101, 4'b0100, 4'b0000, 4'b0100, {8'h09,8'h01,8'h00,8'h05}, 4'b0100, 4'b0010, 8'h08};
    vecs[8]  = '{1'b0, 1'b1, 4'b1001, 4'b0000, 4'b0000, 4'b0000, {8'h09,8'h01,8'h00,8'h05}, 4'b1000, 4'b0010, 8'h0C};
    vecs[9]  = '{1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, {8'h09,8'h01,8'h00,8'h05}, 4'b0001, 4'b0010, 8'h00};
    // all four banks at once, PE1/PE3 single-packet writes that must not lock
    vecs[10] = '{1'b0, 1'b1, 4'b1111, 4'b1010, 4'b1010, 4'b1010, {8'h23,8'h22,8'h21,8'h20}, 4'b1111, 4'b1111, 8'hE4};
    vecs[11] = '{1'b0, 1'b1, 4'b0101, 4'b0000, 4'b0000, 4'b0000, {8'h00,8'h33,8'h00,8'h31}, 4'b0101, 4'b1010, 8'h80};
    // available low blocks PE1 for two cycles
    vecs[12] = '{1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, {8'h00,8'h00,8'h02,8'h00}, 4'b0000, 4'b0000, 8'h00};
    vecs[13] = '{1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, {8'h00,8'h00,8'h02,8'h00}, 4'b0000, 4'b0000, 8'h00};
    vecs[14] = '{1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, {8'h00,8'h00,8'h02,8'h00}, 4'b0010, 4'b0100, 8'h10};
    // reset in the middle of PE1's stream to bank 3 drops the lock
    vecs[15] = '{1'b1, 1'b1, 4'b0010, 4'b0010, 4'b0010, 4'b0000, {8'h00,8'h00,8'h03,8'h00}, 4'b0010, 4'b1000, 8'h40};
    vecs[16] = '{1'b1, 1'b1, 4'b0011, 4'b0010, 4'b0000, 4'b0000, {8'h00,8'h00,8'h03,8'h07}, 4'b0001, 4'b1000, 8'h00};

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst_before) begin
        do_reset();
      end
      apply(i);
    end

    // Idle cycle after the last grant: valid drops, fields hold
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
    shadow.bv = '0;
    compare_bank("idle", shadow);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
